// File: rtl/oflow_core_set_scheduler.sv
// oflow_core_set_scheduler
// Frame/set sequencer for the oflow core. A frame of up to MAX_BBOX bboxes is
// split into sets of PE_NUM. Each set is handshaken with the DMA, then runs
// feature extraction and registration on its active PEs only. After the last
// set the buffer write is triggered and the frame counter advances.
// Optional feature macro: OFLOW_SCHED_OVERLAP_EN. When it is defined, the FE
// of set k+1 may be launched while set k is still in registration.
module oflow_core_set_scheduler #(
    parameter int PE_NUM   = 24,
    parameter int MAX_BBOX = 48,
    parameter int FRAME_W  = 8,
    parameter int CNT_W    = $clog2(MAX_BBOX + 1),
    parameter int SET_W    = $clog2(MAX_BBOX / PE_NUM + 2)
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start,
    input  logic               new_frame,
    input  logic [CNT_W-1:0]   num_of_bbox_in_frame,
    output logic               ready_new_frame,
    input  logic               new_set_from_dma,
    output logic               ready_new_set,
    output logic [PE_NUM-1:0]  start_fe,
    input  logic [PE_NUM-1:0]  done_fe,
    output logic [PE_NUM-1:0]  start_registration,
    input  logic [PE_NUM-1:0]  done_registration,
    output logic               start_write_mem,
    input  logic               done_write,
    output logic               rnw_st,
    output logic [PE_NUM-1:0]  active_mask,
    output logic [SET_W-1:0]   set_idx,
    output logic [FRAME_W-1:0] frame_num,
    output logic               done_frame,
    output logic               valid_id
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_WAIT_SET   = 3'd2,
        ST_FE         = 3'd3,
        ST_REG        = 3'd4,
        ST_WRITE      = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam logic [PE_NUM-1:0] MASK_ZERO = {PE_NUM{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    // LSB-packed mask with min(PE_NUM, rem) bits set.
    function automatic logic [PE_NUM-1:0] mask_of(input logic [CNT_W-1:0] rem);
        logic [PE_NUM-1:0] m;
        m = {PE_NUM{1'b0}};
        for (int i = 0; i < PE_NUM; i++) begin
            if (i < int'(rem)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Number of PEs enabled in a mask, in bbox-count width.
    function automatic logic [CNT_W-1:0] popcount(input logic [PE_NUM-1:0] m);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < PE_NUM; i++) begin
            cnt = cnt + CNT_W'(m[i]);
        end
        return cnt;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [SET_W-1:0]   set_idx_q, set_idx_d;
    logic [PE_NUM-1:0]  mask_q, mask_d;
    logic [PE_NUM-1:0]  sticky_fe_q, sticky_fe_d;
    logic [PE_NUM-1:0]  sticky_reg_q, sticky_reg_d;
    logic [PE_NUM-1:0]  start_reg_q, start_reg_d;
    logic               start_wr_q, start_wr_d;
    logic               rnw_q, rnw_d;
    logic               done_frame_q, done_frame_d;
    logic [FRAME_W-1:0] frame_num_q, frame_num_d;
    logic               ready_frame_q, ready_frame_d;
    logic               ready_set_q, ready_set_d;
    logic [PE_NUM-1:0]  start_fe_s;
    logic [CNT_W-1:0]   n_clamp_s;
    logic [CNT_W-1:0]   rem_after_s;
    logic [PE_NUM-1:0]  reg_seen_s;
    logic               fe_all_s;
    logic               reg_all_s;
`ifdef OFLOW_SCHED_OVERLAP_EN
    logic [PE_NUM-1:0]  nxt_mask_q, nxt_mask_d;
    logic [PE_NUM-1:0]  nxt_sticky_q, nxt_sticky_d;
    logic               nxt_launched_q, nxt_launched_d;
    logic               can_launch_s;
    logic               nxt_fe_all_s;
`endif

    // Next-state, datapath updates and output pulses for the set sequencer.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        set_idx_d     = set_idx_q;
        mask_d        = mask_q;
        sticky_fe_d   = sticky_fe_q;
        sticky_reg_d  = sticky_reg_q;
        start_reg_d   = MASK_ZERO;
        start_wr_d    = 1'b0;
        done_frame_d  = 1'b0;
        frame_num_d   = frame_num_q;
        start_fe_s    = MASK_ZERO;

        if (num_of_bbox_in_frame > CNT_W'(MAX_BBOX)) begin
            n_clamp_s = CNT_W'(MAX_BBOX);
        end else begin
            n_clamp_s = num_of_bbox_in_frame;
        end
        rem_after_s = remaining_q - popcount(mask_q);
        fe_all_s    = (((sticky_fe_q | done_fe) & mask_q) == mask_q);
        // The registration start cycle ignores done pulses; sampling begins after it.
        if (start_reg_q != MASK_ZERO) begin
            reg_seen_s = MASK_ZERO;
        end else begin
            reg_seen_s = sticky_reg_q | done_registration;
        end
        reg_all_s = ((reg_seen_s & mask_q) == mask_q);

`ifdef OFLOW_SCHED_OVERLAP_EN
        nxt_mask_d     = nxt_mask_q;
        nxt_sticky_d   = nxt_sticky_q;
        nxt_launched_d = nxt_launched_q;
        can_launch_s   = (rem_after_s != CNT_ZERO) && !nxt_launched_q;
        nxt_fe_all_s   = (((nxt_sticky_q | done_fe) & nxt_mask_q) == nxt_mask_q);
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_FRAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_FRAME: begin
                if (new_frame) begin
                    remaining_d = n_clamp_s;
                    set_idx_d   = {SET_W{1'b0}};
                    if (n_clamp_s == CNT_ZERO) begin
                        state_d      = ST_DONE;
                        done_frame_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_SET;
                    end
                end else begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_SET: begin
                if (new_set_from_dma) begin
                    mask_d      = mask_of(remaining_q);
                    start_fe_s  = mask_d;
                    sticky_fe_d = MASK_ZERO;
                    state_d     = ST_FE;
                end else begin
                    state_d = ST_WAIT_SET;
                end
            end
            ST_FE: begin
                sticky_fe_d = sticky_fe_q | (done_fe & mask_q);
                if (fe_all_s) begin
                    state_d      = ST_REG;
                    start_reg_d  = mask_q;
                    sticky_reg_d = MASK_ZERO;
                end else begin
                    state_d = ST_FE;
                end
            end
            ST_REG: begin
                sticky_reg_d = reg_seen_s & mask_q;
`ifdef OFLOW_SCHED_OVERLAP_EN
                if (can_launch_s && new_set_from_dma) begin
                    nxt_mask_d     = mask_of(rem_after_s);
                    start_fe_s     = nxt_mask_d;
                    nxt_sticky_d   = MASK_ZERO;
                    nxt_launched_d = 1'b1;
                end else if (nxt_launched_q) begin
                    nxt_sticky_d = nxt_sticky_q | (done_fe & nxt_mask_q);
                end else begin
                    nxt_sticky_d = nxt_sticky_q;
                end
`endif
                if (reg_all_s) begin
                    remaining_d  = rem_after_s;
                    set_idx_d    = set_idx_q + SET_W'(1'b1);
                    sticky_reg_d = MASK_ZERO;
`ifdef OFLOW_SCHED_OVERLAP_EN
                    if (nxt_launched_d && !nxt_launched_q) begin
                        // next FE launched in this very cycle: wait for it in FE
                        state_d        = ST_FE;
                        mask_d         = nxt_mask_d;
                        sticky_fe_d    = MASK_ZERO;
                        nxt_launched_d = 1'b0;
                    end else if (nxt_launched_q && nxt_fe_all_s) begin
                        state_d        = ST_REG;
                        mask_d         = nxt_mask_q;
                        start_reg_d    = nxt_mask_q;
                        nxt_launched_d = 1'b0;
                    end else if (nxt_launched_q) begin
                        state_d        = ST_FE;
                        mask_d         = nxt_mask_q;
                        sticky_fe_d    = nxt_sticky_d;
                        nxt_launched_d = 1'b0;
                    end else
`endif
                    if (rem_after_s != CNT_ZERO) begin
                        state_d = ST_WAIT_SET;
                    end else begin
                        state_d    = ST_WRITE;
                        start_wr_d = 1'b1;
                    end
                end else begin
                    state_d = ST_REG;
                end
            end
            ST_WRITE: begin
                if (done_write) begin
                    state_d      = ST_DONE;
                    done_frame_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                frame_num_d = frame_num_q + FRAME_W'(1'b1);
                state_d     = ST_WAIT_FRAME;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rnw_d         = (state_d != ST_WRITE);
        ready_frame_d = (state_d == ST_WAIT_FRAME);
        ready_set_d   = (state_d == ST_WAIT_SET);
`ifdef OFLOW_SCHED_OVERLAP_EN
        if ((state_d == ST_REG) && !nxt_launched_d &&
            ((remaining_d - popcount(mask_d)) != CNT_ZERO)) begin
            ready_set_d = 1'b1;
        end else begin
            ready_set_d = (state_d == ST_WAIT_SET);
        end
`endif
    end

    // State and output registers; reset abandons all progress.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q       <= ST_IDLE;
            remaining_q   <= {CNT_W{1'b0}};
            set_idx_q     <= {SET_W{1'b0}};
            mask_q        <= {PE_NUM{1'b0}};
            sticky_fe_q   <= {PE_NUM{1'b0}};
            sticky_reg_q  <= {PE_NUM{1'b0}};
            start_reg_q   <= {PE_NUM{1'b0}};
            start_wr_q    <= 1'b0;
            rnw_q         <= 1'b1;
            done_frame_q  <= 1'b0;
            frame_num_q   <= {FRAME_W{1'b0}};
            ready_frame_q <= 1'b0;
            ready_set_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            set_idx_q     <= set_idx_d;
            mask_q        <= mask_d;
            sticky_fe_q   <= sticky_fe_d;
            sticky_reg_q  <= sticky_reg_d;
            start_reg_q   <= start_reg_d;
            start_wr_q    <= start_wr_d;
            rnw_q         <= rnw_d;
            done_frame_q  <= done_frame_d;
            frame_num_q   <= frame_num_d;
            ready_frame_q <= ready_frame_d;
            ready_set_q   <= ready_set_d;
        end
    end

`ifdef OFLOW_SCHED_OVERLAP_EN
    // Registers for the look-ahead set whose FE overlaps current registration.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            nxt_mask_q     <= {PE_NUM{1'b0}};
            nxt_sticky_q   <= {PE_NUM{1'b0}};
            nxt_launched_q <= 1'b0;
        end else begin
            nxt_mask_q     <= nxt_mask_d;
            nxt_sticky_q   <= nxt_sticky_d;
            nxt_launched_q <= nxt_launched_d;
        end
    end
`endif

    // start_fe is combinational so the DMA handshake launches FE with zero latency.
    assign start_fe           = start_fe_s;
    assign start_registration = start_reg_q;
    assign start_write_mem    = start_wr_q;
    assign rnw_st             = rnw_q;
    assign active_mask        = mask_q;
    assign set_idx            = set_idx_q;
    assign frame_num          = frame_num_q;
    assign done_frame         = done_frame_q;
    assign valid_id           = done_frame_q;
    assign ready_new_frame    = ready_frame_q;
    assign ready_new_set      = ready_set_q;

endmodule
